// File: rtl/multicyc_exec_pkg.sv
// Shared types and op-class helpers for the multi-cycle execution unit.
// Request/response bundles exchanged with the EX stage live here.
package multicyc_exec_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_MUL   = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_DIV   = 4'd8,
        OP_DIVU  = 4'd9
    } oper_t;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} multicyc_state_t;

    typedef struct packed {
        oper_t       op;
        logic        is_multicyc;
        logic [63:0] hilo;
        logic [31:0] reg0;
        logic [31:0] reg1;
    } multicyc_req_t;

    typedef struct packed {
        logic        ready;
        logic        valid;
        logic [63:0] hilo;
    } multicyc_resp_t;

    function automatic logic is_mul_op(oper_t op);
        return op inside {OP_MULT, OP_MULTU, OP_MUL, OP_MADD,
                          OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_div_op(oper_t op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_signed_op(oper_t op);
        return op inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB, OP_DIV};
    endfunction

endpackage

// File: rtl/multicyc_exec_div_unit.sv
// Iterative restoring divider on magnitudes with a final sign-fixup cycle.
// One load cycle, 32/BITS iteration cycles, one fixup cycle, then done pulses.
module div_unit #(
    parameter int BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    localparam int ITER = 32 / BITS;

    logic [31:0] rem_q, quot_q, dvs_q;
    logic [31:0] rem_n, quot_n;
    logic [32:0] trial;
    logic [5:0]  cnt_q;
    logic        busy_q, qneg_q, rneg_q;
    logic        a_neg, b_neg;

    assign a_neg = signed_op & dividend[31];
    assign b_neg = signed_op & divisor[31];

    always_comb begin
        rem_n  = rem_q;
        quot_n = quot_q;
        trial  = '0;
        for (int i = 0; i < BITS; i++) begin
            trial  = {rem_n, quot_n[31]};
            quot_n = {quot_n[30:0], 1'b0};
            if (trial >= {1'b0, dvs_q}) begin
                trial     = trial - {1'b0, dvs_q};
                quot_n[0] = 1'b1;
            end
            rem_n = trial[31:0];
        end
    end

    // A zero divisor is not special-cased: every trial subtract succeeds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            quot_q    <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else if (flush) begin
            busy_q <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q  <= '0;
                quot_q <= a_neg ? -dividend : dividend;
                dvs_q  <= b_neg ? -divisor : divisor;
                qneg_q <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                cnt_q  <= 6'(ITER);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                if (cnt_q != '0) begin
                    rem_q  <= rem_n;
                    quot_q <= quot_n;
                    cnt_q  <= cnt_q - 6'd1;
                end else begin
                    quotient  <= qneg_q ? -quot_q : quot_q;
                    remainder <= rneg_q ? -rem_q : rem_q;
                    busy_q    <= 1'b0;
                    done      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multicyc_exec.sv
// Multi-cycle MUL/MADD/MSUB/DIV sequencer beside the EX stage.
// Holds its result until acked; flush abandons any operation in flight.
module multicyc_exec
    import multicyc_exec_pkg::*;
#(
    parameter int MUL_LATENCY        = 3,
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           ack,
    input  multicyc_req_t  req,
    output multicyc_resp_t resp
);

    localparam int CW = $clog2(MUL_LATENCY + 1);

    multicyc_state_t state_q, state_d;
    oper_t           op_q;
    logic [63:0]     hilo_q, result_q, mul_res;
    logic [63:0]     pipe_q [MUL_LATENCY];
    logic [63:0]     opa, opb;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     quot, rem;
    logic            div_done, start, sgn;

    assign start = (state_q == IDLE) && req.is_multicyc && !flush;
    assign sgn   = is_signed_op(req.op);
    assign opa   = {{32{sgn & req.reg0[31]}}, req.reg0};
    assign opb   = {{32{sgn & req.reg1[31]}}, req.reg1};

    div_unit #(
        .BITS(DIV_BITS_PER_CYCLE)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .start    (start && is_div_op(req.op)),
        .signed_op(sgn),
        .dividend (req.reg0),
        .divisor  (req.reg1),
        .quotient (quot),
        .remainder(rem),
        .done     (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (req.is_multicyc)
                          state_d = is_mul_op(req.op) ? MUL :
                                    is_div_op(req.op) ? DIV : DONE;
                MUL:  if (cnt_q == CW'(MUL_LATENCY - 1)) state_d = DONE;
                DIV:  if (div_done) state_d = DONE;
                DONE: if (ack) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_NOP;
            hilo_q <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            op_q   <= req.op;
            hilo_q <= req.hilo;
            cnt_q  <= '0;
        end else if (state_q == MUL) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Product enters at the start edge and shifts one stage per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LATENCY; i++) pipe_q[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < MUL_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            if (start) pipe_q[0] <= opa * opb;
            for (int i = 1; i < MUL_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_comb begin
        mul_res = pipe_q[MUL_LATENCY-1];
        if (op_q inside {OP_MADD, OP_MADDU})
            mul_res = hilo_q + pipe_q[MUL_LATENCY-1];
        else if (op_q inside {OP_MSUB, OP_MSUBU})
            mul_res = hilo_q - pipe_q[MUL_LATENCY-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            result_q <= '0;
        else if (start && !is_mul_op(req.op) && !is_div_op(req.op))
            result_q <= req.hilo;
        else if (state_q == MUL && state_d == DONE)
            result_q <= mul_res;
        else if (state_q == DIV && state_d == DONE)
            result_q <= {rem, quot};
    end

    always_comb begin
        resp = '0;
        if (state_q == IDLE && !req.is_multicyc) begin
            resp.valid = 1'b1;
            resp.hilo  = req.hilo;
        end else if (state_q == DONE) begin
            resp.valid = 1'b1;
            resp.hilo  = result_q;
        end
        resp.ready = resp.valid;
    end

endmodule

// File: tb/tb_multicyc_exec.sv
// Randomized self-checking bench for multicyc_exec.
// Expected results and latencies come from a plain-arithmetic reference model.
module tb_multicyc_exec;
    import multicyc_exec_pkg::*;

    localparam int MLAT  = 3;
    localparam int DBITS = 1;
    localparam int DLAT  = 2 + 32 / DBITS;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           ack   = 1'b0;
    multicyc_req_t  req;
    multicyc_resp_t resp;
    int             checks   = 0;
    int             failures = 0;

    always #5 clk = ~clk;

    multicyc_exec #(
        .MUL_LATENCY       (MLAT),
        .DIV_BITS_PER_CYCLE(DBITS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .ack  (ack),
        .req  (req),
        .resp (resp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(oper_t op, logic [63:0] h,
                                          logic [31:0] a, logic [31:0] b);
        longint sa, sb, ua, ub, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            OP_MULT, OP_MUL: return 64'(sa * sb);
            OP_MULTU:        return 64'(ua * ub);
            OP_MADD:         return h + 64'(sa * sb);
            OP_MADDU:        return h + 64'(ua * ub);
            OP_MSUB:         return h - 64'(sa * sb);
            OP_MSUBU:        return h - 64'(ua * ub);
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            OP_DIV: begin
                if (b == 32'd0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            default: return h;
        endcase
    endfunction

    task automatic run_op(string name, oper_t op, logic [63:0] h,
                          logic [31:0] a, logic [31:0] b, bit noisy);
        logic [63:0] exp, pt;
        int n, lat;
        exp = model(op, h, a, b);
        lat = is_mul_op(op) ? MLAT : (is_div_op(op) ? DLAT : 0);
        req.op = op;
        req.is_multicyc = 1'b1;
        req.hilo = h;
        req.reg0 = a;
        req.reg1 = b;
        #1;
        checks++;
        if (resp.valid !== 1'b0)
            $display("FAIL %s pre-start valid: got %b want 0", name, resp.valid);
        tick();
        req.reg0 = $urandom;
        req.reg1 = $urandom;
        req.hilo = {$urandom, $urandom};
        req.op   = oper_t'($urandom_range(1, 9));
        ack = noisy;
        #1;
        n = 0;
        while (!resp.valid && n < 200) begin
            tick();
            n++;
        end
        ack = 1'b0;
        #1;
        checks++;
        if (n !== lat) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, n, lat);
        end
        checks++;
        if (resp.hilo !== exp) begin
            failures++;
            $display("FAIL %s result: got %h want %h", name, resp.hilo, exp);
        end
        repeat (2) tick();
        checks++;
        if (resp.valid !== 1'b1 || resp.ready !== 1'b1 || resp.hilo !== exp) begin
            failures++;
            $display("FAIL %s hold: got v=%b r=%b %h want 1 1 %h",
                     name, resp.valid, resp.ready, resp.hilo, exp);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        #1;
        checks++;
        if (resp.valid !== 1'b0) begin
            failures++;
            $display("FAIL %s bubble: got valid=%b want 0", name, resp.valid);
        end
        pt = {$urandom, $urandom};
        req.is_multicyc = 1'b0;
        req.hilo = pt;
        #1;
        checks++;
        if (resp.valid !== 1'b1 || resp.hilo !== pt) begin
            failures++;
            $display("FAIL %s idle-after-ack: got v=%b %h want 1 %h",
                     name, resp.valid, resp.hilo, pt);
        end
    endtask

    task automatic test_reset();
        req = '0;
        req.is_multicyc = 1'b1;
        req.op = OP_MULT;
        req.hilo = 64'hDEAD_BEEF_0123_4567;
        rst_n = 1'b0;
        #2;
        checks++;
        if (resp.valid !== 1'b0 || resp.ready !== 1'b0 || resp.hilo !== 64'd0) begin
            failures++;
            $display("FAIL reset: got v=%b r=%b %h want 0 0 0",
                     resp.valid, resp.ready, resp.hilo);
        end
        repeat (2) tick();
        req.is_multicyc = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (resp.valid !== 1'b1 || resp.hilo !== 64'hDEAD_BEEF_0123_4567) begin
            failures++;
            $display("FAIL reset-release idle: got v=%b %h", resp.valid, resp.hilo);
        end
    endtask

    task automatic test_passthru();
        logic [63:0] h;
        for (int i = 0; i < 8; i++) begin
            h = {$urandom, $urandom};
            req.is_multicyc = 1'b0;
            req.op = oper_t'($urandom_range(0, 9));
            req.hilo = h;
            ack = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (resp.valid !== 1'b1 || resp.ready !== 1'b1 || resp.hilo !== h) begin
                failures++;
                $display("FAIL passthru %0d: got v=%b %h want 1 %h",
                         i, resp.valid, resp.hilo, h);
            end
            tick();
        end
        ack = 1'b0;
    endtask

    task automatic test_mul();
        run_op("mult_neg", OP_MULT, 64'd0, 32'hFFFF_FFFB, 32'd3, 1'b0);
        run_op("maddu", OP_MADDU, 64'h0000_0001_FFFF_FFFF, 32'd2, 32'd2, 1'b0);
        run_op("msub", OP_MSUB, 64'd0, 32'd1, 32'd1, 1'b0);
        run_op("mul_gpr", OP_MUL, 64'h1234, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("multu_max", OP_MULTU, 64'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 20; i++)
            run_op("mul_rand", oper_t'($urandom_range(1, 7)), {$urandom, $urandom},
                   $urandom, $urandom, 1'($urandom_range(0, 1)));
    endtask

    task automatic test_div();
        run_op("div_neg", OP_DIV, 64'd0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu", OP_DIVU, 64'd0, 32'd100, 32'd7, 1'b0);
        run_op("divu_zero", OP_DIVU, 64'd0, 32'h1234_5678, 32'd0, 1'b0);
        run_op("div_ovf", OP_DIV, 64'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("div_zero_neg", OP_DIV, 64'd0, 32'hFFFF_FFF7, 32'd0, 1'b0);
        run_op("div_zero_pos", OP_DIV, 64'd0, 32'd9, 32'd0, 1'b0);
        for (int i = 0; i < 8; i++)
            run_op("div_rand", oper_t'($urandom_range(8, 9)), {$urandom, $urandom},
                   $urandom, (i < 4) ? 32'($urandom_range(1, 300)) : $urandom,
                   1'($urandom_range(0, 1)));
    endtask

    task automatic test_unsupported();
        run_op("unsup_c", oper_t'(4'hC), 64'hCAFE_F00D_0BAD_BEEF, $urandom, $urandom, 1'b0);
        run_op("unsup_nop", OP_NOP, {$urandom, $urandom}, $urandom, $urandom, 1'b1);
    endtask

    task automatic test_flush();
        logic [63:0] pt;
        int bad;
        req.op = OP_DIV;
        req.is_multicyc = 1'b1;
        req.reg0 = $urandom;
        req.reg1 = 32'd3;
        tick();
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pt = {$urandom, $urandom};
        req.is_multicyc = 1'b0;
        req.hilo = pt;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (resp.valid !== 1'b1 || resp.hilo !== pt) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL flush_div: got %0d non-idle cycles want 0", bad);
        end
        run_op("multu_after_flush", OP_MULTU, 64'd0, 32'd2, 32'd3, 1'b0);
        run_op("div_after_flush", OP_DIV, 64'd0, $urandom, $urandom, 1'b0);

        req.op = OP_MULT;
        req.is_multicyc = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pt = {$urandom, $urandom};
        req.is_multicyc = 1'b0;
        req.hilo = pt;
        #1;
        checks++;
        if (resp.valid !== 1'b1 || resp.hilo !== pt) begin
            failures++;
            $display("FAIL flush_start: got v=%b %h want 1 %h", resp.valid, resp.hilo, pt);
        end

        req.op = OP_MULTU;
        req.is_multicyc = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bad = 0;
        for (int i = 0; i < 2 * MLAT; i++) begin
            if (resp.valid !== 1'b0) bad++;
            flush = 1'b1;
            tick();
        end
        flush = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL flush_mul: got %0d valid cycles want 0", bad);
        end

        req.is_multicyc = 1'b0;
        tick();
        req.op = OP_MULT;
        req.is_multicyc = 1'b1;
        req.reg0 = 32'd5;
        req.reg1 = 32'd7;
        tick();
        repeat (MLAT) tick();
        checks++;
        if (resp.valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_ack pre: got valid=%b want 1", resp.valid);
        end
        flush = 1'b1;
        ack = 1'b1;
        tick();
        flush = 1'b0;
        ack = 1'b0;
        #1;
        checks++;
        if (resp.valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_ack: got valid=%b want 0", resp.valid);
        end
        req.is_multicyc = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        req.op = OP_MADD;
        req.is_multicyc = 1'b1;
        req.hilo = {$urandom, $urandom};
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp.valid !== 1'b0 || resp.hilo !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid_mul: got v=%b %h want 0 0", resp.valid, resp.hilo);
        end
        tick();
        req.is_multicyc = 1'b0;
        rst_n = 1'b1;
        tick();
        req.op = OP_MULT;
        req.is_multicyc = 1'b1;
        req.reg0 = $urandom;
        req.reg1 = $urandom;
        tick();
        repeat (MLAT) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp.valid !== 1'b0 || resp.hilo !== 64'd0) begin
            failures++;
            $display("FAIL reset_done: got v=%b %h want 0 0", resp.valid, resp.hilo);
        end
        tick();
        req.is_multicyc = 1'b0;
        rst_n = 1'b1;
        tick();
        run_op("mult_after_reset", OP_MULT, 64'd0, $urandom, $urandom, 1'b0);
    endtask

    initial begin
        test_reset();
        test_passthru();
        test_mul();
        test_div();
        test_unsupported();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicyc_exec.md
Name: multicyc_exec

Overview:
- Sequencing controller for the multi-cycle arithmetic datapath: MULT/MULTU/MUL/MADD/MADDU/MSUB/MSUBU/DIV/DIVU.
- Sits beside the EX stage. Accepts multicyc_req_t, returns multicyc_resp_t.
- Latches operands at start. Runs a pipelined multiplier or an iterative divider. Holds the result until the pipeline acknowledges it. Aborts on flush.

Parameters:
- MUL_LATENCY, 3, cycles from start edge to resp.valid for multiply-class ops; legal range >=1.
- DIV_BITS_PER_CYCLE, 1, quotient bits resolved per divider iteration; legal values 1, 2, 4.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  pipeline flush; abandons any operation in flight.
- ack  input  1  pipeline has consumed the result this cycle.
- req  input  $bits(multicyc_req_t)  op, is_multicyc, hilo (current HI/LO), reg0 (rs), reg1 (rt).
- resp  output  $bits(multicyc_resp_t)  ready, valid (always equal), hilo result {hi,lo}.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - resp.valid=resp.ready=0, resp.hilo=0.
  - Divider and multiplier pipeline registers cleared.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - If req.is_multicyc=0: resp.valid=1 combinationally and resp.hilo=req.hilo (pass-through, no stall).
  - If req.is_multicyc=1 and flush=0: latch op, reg0, reg1 and req.hilo at the clock edge. Go to MUL (multiply-class) or DIV (DIV/DIVU).
  - resp.valid=0 while is_multicyc=1.
  - Multicyc op with an op outside the supported set: go directly to DONE with hilo unchanged.
- MUL:
  - 64-bit product. Signed for MULT/MUL/MADD/MSUB, unsigned for MULTU/MADDU/MSUBU.
  - After MUL_LATENCY cycles from the start edge, go to DONE.
  - Results:
    - MULT/MULTU/MUL: hilo=product.
    - MADD/MADDU: latched_hilo+product, mod 2^64.
    - MSUB/MSUBU: latched_hilo-product, mod 2^64.
  - MUL: the GPR takes hilo[31:0]; HI/LO writeback is suppressed by the pipeline, not by this block.
- DIV:
  - Division runs on magnitudes. 1 load cycle, then 32/DIV_BITS_PER_CYCLE iterations, then 1 sign-fixup cycle.
  - resp.valid at start+2+32/DIV_BITS_PER_CYCLE; default is 34.
  - Result: hi=remainder, lo=quotient.
  - Signed signs: quotient sign = sign(rs) xor sign(rt); remainder sign = sign(rs).
  - Divide by zero: no exception, and the algorithm runs unchanged.
    - Unsigned: lo=0xFFFFFFFF, hi=rs.
    - Signed: magnitude result, then fixup as above.
  - 0x80000000 / -1 (signed): lo=0x80000000, hi=0.
- DONE:
  - resp.valid=1 and resp.hilo held stable until ack=1.
  - On ack, go to IDLE. A new multicyc request is started no earlier than the following cycle (one-cycle bubble).
- flush:
  - Highest priority after reset. From any state, next state is IDLE and resp.valid=0 in the next cycle.
  - In-flight multiplier/divider results are discarded.
  - flush in the same cycle as a would-be start: no start.
  - flush and ack together in DONE: IDLE, no double-consume.
- req ignored outside IDLE: operands may change without effect.
- ack outside DONE is ignored.
- Reset mid-operation: immediate IDLE, no output glitch beyond async clear.

Decomposition:
- Shared package (cpu_defs.svh):
  - multicyc_state_t enum {IDLE, MUL, DIV, DONE}.
  - Op-class helper functions is_mul_op(oper_t), is_div_op(oper_t), is_signed_op(oper_t).
  - `DIV_LATENCY macro derived from DIV_BITS_PER_CYCLE.
- Sub-module div_unit:
  - Iterative restoring divider with start/flush/done.
  - Inputs: signed flag, dividend, divisor.
  - Outputs: quotient, remainder, done pulse.
  - Same clk/rst_n.
- Multiplier: inferred, MUL_LATENCY-deep register chain inside this module.

Test Plan:
- MULT rs=0xFFFFFFFB (-5), rt=3, start at T -> resp.valid at T+3, hilo=0xFFFFFFFF_FFFFFFF1; held until ack, IDLE next cycle.
- MADDU req.hilo=0x00000001_FFFFFFFF, rs=rt=0x00000002 -> hilo=0x00000002_00000003; MSUB hilo=0, rs=1, rt=1 -> hilo=0xFFFFFFFF_FFFFFFFF.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> valid at T+34, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
- DIVU rs=0x12345678, rt=0 -> lo=0xFFFFFFFF, hi=0x12345678; signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- flush at T+10 of a DIV -> valid never asserts, IDLE at T+11; following MULTU 2*3 returns hilo=6 after 3 cycles; flush concurrent with a start -> no operation.
- Non-multicyc req (is_multicyc=0) in IDLE -> valid=1 same cycle, hilo=req.hilo; rst_n low during MUL -> valid=0 and hilo=0 immediately.
